time_set_editor: RTL and testbench

//  Button-driven editor that produces the packed time-set bus consumed by the clock core
//  (stime[19:0], sam_pm, set_time). Snapshots the running time, lets the user step hours,

---
 rtl/time_set_editor.sv | 279 +++++++++++++++++++++++++++
 tb/tb_time_set_editor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_editor.sv
// ---------------------------------------------------------------------------
// time_set_editor
//
// Button-driven editor for the clock core's time-set bus. A mode press
// snapshots the running time. The user then steps hours, minutes and seconds,
// plus AM/PM when the time was snapshotted in 12h mode. The last mode press
// commits the edit: the new time is driven on stime/sam_pm and set_time is
// held high for SET_HOLD cycles, long enough for the core's slow counters to
// see a trigger edge while set is asserted.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   btn_mode   in   level; a rising edge enters edit mode or advances the field
//   btn_inc    in   level; a rising edge increments the current field
//   btn_dec    in   level; a rising edge decrements the current field
//   btn_cancel in   level; a rising edge abandons the edit with no commit
//   mode12h    in   1 = 12h entry (hours 0..11 + AM/PM), 0 = 24h entry
//   cur_time   in   running time {h1[1:0],h0[3:0],m1[2:0],m0[3:0],s1[2:0],s0[3:0]}
//   cur_am_pm  in   running AM/PM flag
//   stime      out  edited time, BCD, same packing as cur_time
//   sam_pm     out  edited AM/PM; always 0 for a 24h edit
//   set_time   out  commit strobe, high for exactly SET_HOLD cycles
//   editing    out  high while a field is being edited
//   field_sel  out  0 none, 1 hour, 2 minute, 3 second, 4 AM/PM
// ---------------------------------------------------------------------------
module time_set_editor #(
  parameter int SET_HOLD     = 4,
  parameter int EDIT_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic        mode12h,
  input  logic [19:0] cur_time,
  input  logic        cur_am_pm,
  output logic [19:0] stime,
  output logic        sam_pm,
  output logic        set_time,
  output logic        editing,
  output logic [2:0]  field_sel
);

  localparam int TW = $clog2(EDIT_TIMEOUT + 1);
  localparam int HW = $clog2(SET_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EDIT_HR   = 3'd1,
    S_EDIT_MIN  = 3'd2,
    S_EDIT_SEC  = 3'd3,
    S_EDIT_AMPM = 3'd4,
    S_COMMIT    = 3'd5
  } state_t;

  // Button order inside the vectors: {cancel, mode, inc, dec}
  logic [3:0] btn_vec;
  logic [3:0] prev_q, prev_d;
  logic [3:0] ev;

  logic ev_cancel, ev_mode, ev_inc, ev_dec, ev_any;

  state_t          state_q, state_d;
  logic [4:0]      hr_q, hr_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            pm_q, pm_d;
  logic            m12_q, m12_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [19:0]     stime_q, stime_d;
  logic            sam_pm_q, sam_pm_d;
  logic            set_q, set_d;
  logic            editing_q, editing_d;
  logic [2:0]      field_q, field_d;

  logic [4:0]      hr_max;
  logic [4:0]      snap_hr;
  logic [4:0]      snap_max;

  // ---------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------
  function automatic logic [4:0] bcd2bin_hr(input logic [1:0] t, input logic [3:0] u);
    return ({3'b000, t} * 5'd10) + {1'b0, u};
  endfunction

  function automatic logic [5:0] bcd2bin_ms(input logic [2:0] t, input logic [3:0] u);
    return ({3'b000, t} * 6'd10) + {2'b00, u};
  endfunction

  // Tens come from range compares. Units = v - 10*tens, which can be done in
  // 4-bit arithmetic because the result is always below 16.
  function automatic logic [5:0] bin2bcd_hr(input logic [4:0] v);
    logic [1:0] t;
    logic [3:0] u;
    if (v >= 5'd20)      t = 2'd2;
    else if (v >= 5'd10) t = 2'd1;
    else                 t = 2'd0;
    u = v[3:0] - ({2'b00, t} * 4'd10);
    return {t, u};
  endfunction

  function automatic logic [6:0] bin2bcd_ms(input logic [5:0] v);
    logic [2:0] t;
    logic [3:0] u;
    if (v >= 6'd50)      t = 3'd5;
    else if (v >= 6'd40) t = 3'd4;
    else if (v >= 6'd30) t = 3'd3;
    else if (v >= 6'd20) t = 3'd2;
    else if (v >= 6'd10) t = 3'd1;
    else                 t = 3'd0;
    u = v[3:0] - ({1'b0, t} * 4'd10);
    return {t, u};
  endfunction

  // Modular step over 0..59
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Rising-edge detection, one history register per button
  // ---------------------------------------------------------------------
  assign btn_vec = {btn_cancel, btn_mode, btn_inc, btn_dec};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
      assign ev[gi] = btn_vec[gi] & ~prev_q[gi];
    end
  endgenerate

  assign ev_cancel = ev[3];
  assign ev_mode   = ev[2];
  assign ev_inc    = ev[1];
  assign ev_dec    = ev[0];
  assign ev_any    = |ev;

  assign hr_max   = m12_q ? 5'd11 : 5'd23;
  assign snap_max = mode12h ? 5'd11 : 5'd23;
  assign snap_hr  = bcd2bin_hr(cur_time[19:18], cur_time[17:14]);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    prev_d    = btn_vec;
    state_d   = state_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pm_d      = pm_q;
    m12_d     = m12_q;
    tmo_d     = tmo_q;
    hold_d    = hold_q;
    stime_d   = stime_q;
    sam_pm_d  = sam_pm_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d  = '0;
        hold_d = '0;
        if (ev_mode) begin
          // mode12h is latched here; later changes do not affect this edit
          hr_d    = (snap_hr > snap_max) ? 5'd0 : snap_hr;
          min_d   = bcd2bin_ms(cur_time[13:11], cur_time[10:7]);
          sec_d   = bcd2bin_ms(cur_time[6:4], cur_time[3:0]);
          pm_d    = cur_am_pm;
          m12_d   = mode12h;
          state_d = S_EDIT_HR;
        end
      end

      S_EDIT_HR, S_EDIT_MIN, S_EDIT_SEC, S_EDIT_AMPM: begin
        // Any button edge, including an inc+dec no-op, restarts the timeout
        tmo_d = ev_any ? '0 : tmo_q + TW'(1);

        if (ev_cancel) begin
          state_d = S_IDLE;
        end else if (ev_mode) begin
          if ((state_q == S_EDIT_AMPM) || ((state_q == S_EDIT_SEC) && !m12_q)) begin
            // Commit: the outputs are loaded on the same edge that enters COMMIT
            stime_d  = {bin2bcd_hr(hr_q), bin2bcd_ms(min_q), bin2bcd_ms(sec_q)};
            sam_pm_d = m12_q & pm_q;
            hold_d   = '0;
            state_d  = S_COMMIT;
          end else if (state_q == S_EDIT_HR) begin
            state_d = S_EDIT_MIN;
          end else if (state_q == S_EDIT_MIN) begin
            state_d = S_EDIT_SEC;
          end else begin
            state_d = S_EDIT_AMPM;
          end
        end else if (ev_inc ^ ev_dec) begin
          unique case (state_q)
            S_EDIT_HR: begin
              if (ev_inc) hr_d = (hr_q == hr_max) ? 5'd0 : hr_q + 5'd1;
              else        hr_d = (hr_q == 5'd0) ? hr_max : hr_q - 5'd1;
            end
            S_EDIT_MIN:  min_d = step60(min_q, ev_inc);
            S_EDIT_SEC:  sec_d = step60(sec_q, ev_inc);
            default:     pm_d  = ~pm_q;
          endcase
        end else if (!ev_any && (tmo_q == TW'(EDIT_TIMEOUT - 1))) begin
          // This cycle the quiet count reaches EDIT_TIMEOUT
          state_d = S_IDLE;
        end
      end

      S_COMMIT: begin
        // Buttons are ignored; only the hold counter advances
        if (hold_q == HW'(SET_HOLD - 1)) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    set_d     = (state_d == S_COMMIT);
    editing_d = (state_d == S_EDIT_HR) || (state_d == S_EDIT_MIN) ||
                (state_d == S_EDIT_SEC) || (state_d == S_EDIT_AMPM);
    field_d   = editing_d ? 3'(state_d) : 3'd0;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      state_q   <= S_IDLE;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      pm_q      <= 1'b0;
      m12_q     <= 1'b0;
      tmo_q     <= '0;
      hold_q    <= '0;
      stime_q   <= '0;
      sam_pm_q  <= 1'b0;
      set_q     <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pm_q      <= pm_d;
      m12_q     <= m12_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      stime_q   <= stime_d;
      sam_pm_q  <= sam_pm_d;
      set_q     <= set_d;
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  assign stime     = stime_q;
  assign sam_pm    = sam_pm_q;
  assign set_time  = set_q;
  assign editing   = editing_q;
  assign field_sel = field_q;

endmodule

// File: tb/tb_time_set_editor.sv
// ---------------------------------------------------------------------------
// tb_time_set_editor
//
// Directed stimulus against time_set_editor. A behavioural model tracks the
// editor as a phase number plus plain integer hour/minute/second values. A
// negedge process compares every DUT output with the model on every cycle.
// Literal checks pin the model at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_time_set_editor;

  localparam int HOLD = 4;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec, btn_cancel;
  logic        mode12h;
  logic [19:0] cur_time;
  logic        cur_am_pm;
  logic [19:0] stime;
  logic        sam_pm, set_time, editing;
  logic [2:0]  field_sel;

  always #5 clk = ~clk;

  time_set_editor #(.SET_HOLD(HOLD), .EDIT_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .mode12h    (mode12h),
    .cur_time   (cur_time),
    .cur_am_pm  (cur_am_pm),
    .stime      (stime),
    .sam_pm     (sam_pm),
    .set_time   (set_time),
    .editing    (editing),
    .field_sel  (field_sel)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 hour, 2 minute, 3 second, 4 AM/PM, 5 strobe
  int          m_phase, m_h, m_m, m_s, m_quiet, m_hold;
  bit          m_pm, m_m12;
  bit          pv_mode, pv_inc, pv_dec, pv_cancel;
  logic [19:0] m_stime;
  logic        m_sam;
  bit          chk_en = 1'b0;

  function automatic logic [19:0] pack(int h, int m, int s);
    return 20'(((h / 10) << 18) | ((h % 10) << 14) | ((m / 10) << 11) |
               ((m % 10) << 7) | ((s / 10) << 4) | (s % 10));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_quiet = 0; m_hold = 0;
    m_stime = '0; m_sam = 1'b0;
    pv_mode = 0; pv_inc = 0; pv_dec = 0; pv_cancel = 0;
  endtask

  task automatic model_clock();
    bit em, ei, ed, ec;
    int hm;
    em = btn_mode & ~pv_mode;
    ei = btn_inc & ~pv_inc;
    ed = btn_dec & ~pv_dec;
    ec = btn_cancel & ~pv_cancel;
    pv_mode = btn_mode; pv_inc = btn_inc; pv_dec = btn_dec; pv_cancel = btn_cancel;

    if (m_phase == 5) begin
      m_hold--;
      if (m_hold == 0) m_phase = 0;
    end else if (m_phase == 0) begin
      if (em) begin
        m_h   = cur_time[19:18] * 10 + cur_time[17:14];
        m_m   = cur_time[13:11] * 10 + cur_time[10:7];
        m_s   = cur_time[6:4] * 10 + cur_time[3:0];
        m_pm  = cur_am_pm;
        m_m12 = mode12h;
        if (m_h > (m_m12 ? 11 : 23)) m_h = 0;
        m_quiet = 0;
        m_phase = 1;
      end
    end else begin
      hm = m_m12 ? 11 : 23;
      if (ec | em | ei | ed) m_quiet = 0;
      else                   m_quiet++;
      if (ec) begin
        m_phase = 0;
      end else if (em) begin
        if (m_phase == 4 || (m_phase == 3 && !m_m12)) begin
          m_stime = pack(m_h, m_m, m_s);
          m_sam   = m_m12 && m_pm;
          m_phase = 5;
          m_hold  = HOLD;
        end else begin
          m_phase++;
        end
      end else if (ei ^ ed) begin
        case (m_phase)
          1:       m_h = ei ? (m_h + 1) % (hm + 1) : (m_h + hm) % (hm + 1);
          2:       m_m = ei ? (m_m + 1) % 60 : (m_m + 59) % 60;
          3:       m_s = ei ? (m_s + 1) % 60 : (m_s + 59) % 60;
          default: m_pm = ~m_pm;
        endcase
      end else if (m_quiet >= TMO) begin
        m_phase = 0;
      end
    end
  endtask

  // Inputs change 2 time units after a rising edge; the model steps on the edge
  task automatic cyc(bit m, bit i, bit d, bit c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    @(posedge clk);
    if (rst) model_clock();
    else     model_reset();
    #2;
  endtask

  task automatic press(bit m, bit i, bit d, bit c);
    cyc(m, i, d, c);
    cyc(0, 0, 0, 0);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("stime", stime, m_stime);
      check("sam_pm", sam_pm, m_sam);
      check("set_time", set_time, (m_phase == 5));
      check("editing", editing, (m_phase >= 1 && m_phase <= 4));
      check("field_sel", field_sel, (m_phase >= 1 && m_phase <= 4) ? m_phase : 0);
    end
  end

  int highs;

  initial begin
    rst = 1'b0;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
    mode12h = 0; cur_time = '0; cur_am_pm = 0;
    model_reset();
    #1;
    check("rst_stime", stime, 20'h0);
    check("rst_set_time", set_time, 1'b0);
    check("rst_editing", editing, 1'b0);
    check("rst_field_sel", field_sel, 3'd0);
    check("rst_sam_pm", sam_pm, 1'b0);
    chk_en = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(2);

    // 24h edit: 13:45:07 -> 15:44:07
    cur_time = pack(13, 45, 7);
    press(1, 0, 0, 0);
    check("t24_field_hr", field_sel, 3'd1);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    highs = set_time ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      if (set_time) highs++;
    end
    check("t24_hold_cycles", highs, HOLD);
    check("t24_stime", stime, 20'h56207);
    check("t24_sam_pm", sam_pm, 1'b0);
    check("t24_editing", editing, 1'b0);

    // 12h edit: 11:59:59 AM, hour 11->0, set PM; mode12h change mid-edit is ignored
    mode12h = 1; cur_am_pm = 0;
    cur_time = pack(11, 59, 59);
    press(1, 0, 0, 0);
    check("t12_field_1", field_sel, 3'd1);
    mode12h = 0;
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    check("t12_field_2", field_sel, 3'd2);
    press(1, 0, 0, 0);
    check("t12_field_3", field_sel, 3'd3);
    press(1, 0, 0, 0);
    check("t12_field_4", field_sel, 3'd4);
    press(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("t12_field_0", field_sel, 3'd0);
    check("t12_set_time", set_time, 1'b1);
    idle(6);
    check("t12_stime", stime, 20'h02CD9);
    check("t12_sam_pm", sam_pm, 1'b1);

    // Wraps: hour 00 dec -> 23, minute 59 inc -> 00, second 00 dec -> 59
    cur_time = pack(0, 59, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    idle(6);
    check("wrap_stime", stime, 20'h8C059);

    // inc+dec together leaves the minute unchanged
    cur_time = pack(8, 30, 20);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 1, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    idle(6);
    check("incdec_stime", stime, 20'h21820);

    // cancel+mode together -> back to idle, no strobe
    cur_time = pack(1, 2, 3);
    press(1, 0, 0, 0);
    press(1, 0, 0, 1);
    check("cancel_editing", editing, 1'b0);
    idle(6);
    check("cancel_stime", stime, 20'h21820);

    // Timeout: 1000 quiet cycles after entry returns to idle
    press(1, 0, 0, 0);
    idle(TMO - 2);
    check("tmo_still_editing", editing, 1'b1);
    idle(1);
    check("tmo_editing", editing, 1'b0);
    idle(4);
    check("tmo_stime", stime, 20'h21820);

    // Snapshot hour above the 12h maximum is reduced to 0
    mode12h = 1; cur_am_pm = 1;
    cur_time = pack(13, 0, 0);
    for (int k = 0; k < 5; k++) press(1, 0, 0, 0);
    idle(6);
    check("ovr_stime", stime, 20'h00000);
    check("ovr_sam_pm", sam_pm, 1'b1);
    mode12h = 0; cur_am_pm = 0;

    // Reset during the second cycle of COMMIT, with inc held across reset
    cur_time = pack(13, 45, 7);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("rstc_set_before", set_time, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("rstc_set_time", set_time, 1'b0);
    check("rstc_stime", stime, 20'h0);
    check("rstc_editing", editing, 1'b0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
    check("rstc_after_editing", editing, 1'b0);
    check("rstc_after_set", set_time, 1'b0);
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
